reg_file_sb: RTL and testbench

//  32-entry integer register file with a busy-bit scoreboard, for the RISCAT core.
//  - Write side: a 1-to-32 one-hot decode of the write port.
//  - Read side: two 32:1 read muxes (rs1, rs2).
//  - Adds same-cycle write->read bypass and per-register pending bits for multi-cycle ops (loads).
//  - Sits between decode (reads and reservations) and writeback (writes).

---
 rtl/reg_file_sb.sv | 151 +++++++++++++++
 tb/tb_reg_file_sb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Integer register file (2**ADDR_BITS entries) with a busy-bit scoreboard.
//   Decode reads two operands and may reserve a destination that a
//   multi-cycle op (e.g. a load) will fill later; writeback writes results
//   and clears the matching busy bit.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   rs1_addr, rs2_addr   read indices
//   rs1_data, rs2_data   read values (combinational, with write bypass)
//   rs1_busy, rs2_busy   read register still awaits a pending write
//   wr_en/addr/data      writeback port
//   resv_en, resv_addr   reservation request from decode
//   resv_ok              reservation accepted this cycle (combinational)
//   pending_cnt          registered count of busy bits
module reg_file_sb #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_BITS-1:0] rs1_addr,
    input  logic [ADDR_BITS-1:0] rs2_addr,
    output logic [DATA_BITS-1:0] rs1_data,
    output logic [DATA_BITS-1:0] rs2_data,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 resv_en,
    input  logic [ADDR_BITS-1:0] resv_addr,
    output logic                 resv_ok,
    output logic [ADDR_BITS:0]   pending_cnt
);

    localparam int ENTRIES = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ZERO_ADDR = {ADDR_BITS{1'b0}};

    // Number of set bits in a busy vector.
    function automatic logic [ADDR_BITS:0] popcount(input logic [ENTRIES-1:0] v);
        logic [ADDR_BITS:0] cnt;
        cnt = {(ADDR_BITS+1){1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            cnt = cnt + {{ADDR_BITS{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    logic [DATA_BITS-1:0] regs_r [ENTRIES];
    logic [ENTRIES-1:0]   busy_r;
    logic [ADDR_BITS:0]   pending_cnt_r;

    logic                 wr_act_s;
    logic                 set_s;
    logic [ENTRIES-1:0]   busy_nxt_s;
    logic                 rs1_hit_s;
    logic                 rs2_hit_s;
    logic                 resv_hit_s;

    // Qualify the write strobe and the bypass matches for each consumer.
    always_comb begin
        wr_act_s   = wr_en && (wr_addr != ZERO_ADDR);
        rs1_hit_s  = wr_en && (wr_addr == rs1_addr);
        rs2_hit_s  = wr_en && (wr_addr == rs2_addr);
        resv_hit_s = wr_en && (wr_addr == resv_addr);
    end

    // Read port 1: x0 is hard zero, then same-cycle write bypass, then array.
    always_comb begin
        rs1_data = {DATA_BITS{1'b0}};
        if (rs1_addr == ZERO_ADDR) begin
            rs1_data = {DATA_BITS{1'b0}};
        end else if (rs1_hit_s) begin
            rs1_data = wr_data;
        end else begin
            rs1_data = regs_r[rs1_addr];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rs2_data = {DATA_BITS{1'b0}};
        if (rs2_addr == ZERO_ADDR) begin
            rs2_data = {DATA_BITS{1'b0}};
        end else if (rs2_hit_s) begin
            rs2_data = wr_data;
        end else begin
            rs2_data = regs_r[rs2_addr];
        end
    end

    // Hazard flags; a write landing this cycle resolves the hazard.
    // busy_r[0] is never set, so x0 never reports busy.
    always_comb begin
        rs1_busy = busy_r[rs1_addr] && !rs1_hit_s;
        rs2_busy = busy_r[rs2_addr] && !rs2_hit_s;
    end

    // Reservation grant: refused only while the target is busy and not being
    // written this cycle (WAW guard). x0 is always granted but never marked.
    always_comb begin
        resv_ok = 1'b0;
        if (resv_en) begin
            resv_ok = (resv_addr == ZERO_ADDR) || !busy_r[resv_addr] || resv_hit_s;
        end else begin
            resv_ok = 1'b0;
        end
        set_s = resv_ok && (resv_addr != ZERO_ADDR);
    end

    // Next busy vector: write clears first, so a same-register reservation wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (wr_act_s) begin
            busy_nxt_s[wr_addr] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (set_s) begin
            busy_nxt_s[resv_addr] = 1'b1;
        end else begin
            busy_nxt_s[resv_addr] = busy_nxt_s[resv_addr];
        end
    end

    // Register array write; entry 0 stays zero forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                regs_r[i] <= {DATA_BITS{1'b0}};
            end
        end else if (wr_act_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r        <= {ENTRIES{1'b0}};
            pending_cnt_r <= {(ADDR_BITS+1){1'b0}};
        end else begin
            busy_r        <= busy_nxt_s;
            pending_cnt_r <= popcount(busy_nxt_s);
        end
    end

    assign pending_cnt = pending_cnt_r;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        resv_en;
    logic [4:0]  resv_addr;
    logic        resv_ok;
    logic [5:0]  pending_cnt;

    int n_cmp;
    int n_bad;

    reg_file_sb #(.DATA_BITS(32), .ADDR_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .resv_en(resv_en), .resv_addr(resv_addr), .resv_ok(resv_ok),
        .pending_cnt(pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        resv_en = 1'b0; resv_addr = 5'd0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        idle_inputs();

        // 1. reset state across every index
        #22;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            check_val("rst_rs1_data", rs1_data, 32'd0);
            check_val("rst_rs2_data", rs2_data, 32'd0);
            check_val("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
            check_val("rst_rs2_busy", {31'd0, rs2_busy}, 32'd0);
        end
        check_val("rst_pending", {26'd0, pending_cnt}, 32'd0);

        // 2. write/read and bypass
        tick();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs1_addr = 5'd5;
        #1;
        check_val("x5_bypass", rs1_data, 32'hDEADBEEF);
        tick();
        idle_inputs();
        #1;
        check_val("x5_stored", rs1_data, 32'hDEADBEEF);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00001234; rs2_addr = 5'd7;
        #1;
        check_val("x7_bypass", rs2_data, 32'h00001234);
        tick();
        idle_inputs();
        #1;
        check_val("x7_stored", rs2_data, 32'h00001234);
        check_val("x5_kept", rs1_data, 32'hDEADBEEF);

        // 3. x0 semantics
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rs1_addr = 5'd0;
        #1;
        check_val("x0_bypass_zero", rs1_data, 32'd0);
        tick();
        idle_inputs();
        #1;
        check_val("x0_zero", rs1_data, 32'd0);
        resv_en = 1'b1; resv_addr = 5'd0;
        #1;
        check_val("x0_resv_ok", {31'd0, resv_ok}, 32'd1);
        tick();
        idle_inputs();
        #1;
        check_val("x0_resv_pending", {26'd0, pending_cnt}, 32'd0);
        check_val("x0_busy", {31'd0, rs1_busy}, 32'd0);

        // 4. reserve, WAW refusal, write resolves
        resv_en = 1'b1; resv_addr = 5'd3;
        #1;
        check_val("x3_resv_ok", {31'd0, resv_ok}, 32'd1);
        tick();
        idle_inputs();
        rs1_addr = 5'd3;
        #1;
        check_val("x3_pending1", {26'd0, pending_cnt}, 32'd1);
        check_val("x3_busy", {31'd0, rs1_busy}, 32'd1);
        resv_en = 1'b1; resv_addr = 5'd3;
        #1;
        check_val("x3_rersv_refused", {31'd0, resv_ok}, 32'd0);
        tick();
        idle_inputs();
        #1;
        check_val("x3_pending_held", {26'd0, pending_cnt}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h000000A5;
        #1;
        check_val("x3_wr_busy_clr", {31'd0, rs1_busy}, 32'd0);
        check_val("x3_wr_bypass", rs1_data, 32'h000000A5);
        tick();
        idle_inputs();
        #1;
        check_val("x3_pending0", {26'd0, pending_cnt}, 32'd0);
        check_val("x3_data", rs1_data, 32'h000000A5);
        check_val("x3_busy_after", {31'd0, rs1_busy}, 32'd0);

        // 5. simultaneous write + reserve
        resv_en = 1'b1; resv_addr = 5'd9;
        tick();
        idle_inputs();
        rs1_addr = 5'd9;
        #1;
        check_val("x9_pending1", {26'd0, pending_cnt}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000055;
        resv_en = 1'b1; resv_addr = 5'd9;
        #1;
        check_val("x9_resv_bypass_ok", {31'd0, resv_ok}, 32'd1);
        tick();
        idle_inputs();
        #1;
        check_val("x9_data", rs1_data, 32'h00000055);
        check_val("x9_busy_kept", {31'd0, rs1_busy}, 32'd1);
        check_val("x9_pending_net0", {26'd0, pending_cnt}, 32'd1);
        // not-busy target: write+reserve adds one
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h00000066;
        resv_en = 1'b1; resv_addr = 5'd10;
        tick();
        idle_inputs();
        rs2_addr = 5'd10;
        #1;
        check_val("x10_data", rs2_data, 32'h00000066);
        check_val("x10_busy", {31'd0, rs2_busy}, 32'd1);
        check_val("x10_pending2", {26'd0, pending_cnt}, 32'd2);
        // set x11 while clearing x9: net 0
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000077;
        resv_en = 1'b1; resv_addr = 5'd11;
        tick();
        idle_inputs();
        rs2_addr = 5'd11;
        #1;
        check_val("swap_pending2", {26'd0, pending_cnt}, 32'd2);
        check_val("x9_busy_clr", {31'd0, rs1_busy}, 32'd0);
        check_val("x11_busy", {31'd0, rs2_busy}, 32'd1);
        // write to a non-busy register leaves busy at 0
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h00000012;
        tick();
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h00000010;
        tick();
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h00000011;
        tick();
        idle_inputs();
        rs1_addr = 5'd12;
        #1;
        check_val("x12_not_busy", {31'd0, rs1_busy}, 32'd0);
        check_val("cleared_pending0", {26'd0, pending_cnt}, 32'd0);

        // 6. fill the scoreboard, then reset mid-sequence
        for (int i = 1; i < 32; i++) begin
            resv_en = 1'b1; resv_addr = 5'(i);
            tick();
        end
        idle_inputs();
        #1;
        check_val("full_pending31", {26'd0, pending_cnt}, 32'd31);
        resv_en = 1'b1; resv_addr = 5'd20;
        #1;
        check_val("full_resv_refused", {31'd0, resv_ok}, 32'd0);
        tick();
        check_val("full_pending_cap", {26'd0, pending_cnt}, 32'd31);
        rs1_addr = 5'd5; rs2_addr = 5'd20;
        resv_addr = 5'd0;
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_pending", {26'd0, pending_cnt}, 32'd0);
        check_val("midrst_rs1_data", rs1_data, 32'd0);
        check_val("midrst_rs2_busy", {31'd0, rs2_busy}, 32'd0);
        idle_inputs();
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            #1;
            check_val("post_rst_data", rs1_data, 32'd0);
            check_val("post_rst_busy", {31'd0, rs1_busy}, 32'd0);
        end
        tick();
        check_val("post_rst_pending", {26'd0, pending_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
